// File: rtl/rsa_modexp.sv
// RSA modular-exponentiation engine: R = M^E mod N, byte-wide register access.
// Left-to-right square-and-multiply on top of an interleaved shift/add modular
// multiplier (one bit of A per cycle).
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous reset, active low
//   we       - write strobe, active low (honoured only while ready)
//   oe       - read strobe, active low (write wins when both asserted)
//   start    - begin computation, sampled only while ready
//   reg_sel  - 0 = R (read-only), 1 = M, 2 = E, 3 = N
//   addr     - byte index within the selected register
//   data_i   - write data
//   data_o   - registered read data
//   ready    - 1 = idle / result valid, 0 = busy
module rsa_modexp #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              oe,
  input  logic              start,
  input  logic [1:0]        reg_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              ready
);

  localparam int unsigned NBytes = WIDTH / 8;
  localparam int unsigned CntW   = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StLoad, StTriv, StMmSetup, StMmIter, StDone} state_e;
  typedef enum logic [1:0] {OpReduce, OpSquare, OpMult} op_e;

  state_e state_q, state_d;
  op_e    op_q;

  // Host-visible registers
  logic [WIDTH-1:0] r_q, m_q, e_q, n_q;
  // Working registers
  logic [WIDTH-1:0] m_w_q, e_w_q, n_w_q, acc_q, mr_q, a_q, b_q;
  logic [WIDTH+1:0] p_q;
  logic [CntW-1:0]  cnt_q, bit_idx_q;

  logic [31:0] idx;
  logic        addr_ok, wr_en, rd_en, start_ok;
  logic [7:0]  rd_byte;

  assign idx      = 32'(addr);
  assign addr_ok  = idx < NBytes;
  assign wr_en    = !we && ready && addr_ok && (reg_sel != 2'd0);
  assign rd_en    = !oe && we;
  assign start_ok = start && ready;

  always_comb begin
    rd_byte = 8'h00;
    if (addr_ok) begin
      unique case (reg_sel)
        2'd0: rd_byte = r_q[idx*8 +: 8];
        2'd1: rd_byte = m_q[idx*8 +: 8];
        2'd2: rd_byte = e_q[idx*8 +: 8];
        2'd3: rd_byte = n_q[idx*8 +: 8];
      endcase
    end
  end

  // Host register file and read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      data_o <= 8'h00;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          2'd1:    m_q[idx*8 +: 8] <= data_i;
          2'd2:    e_q[idx*8 +: 8] <= data_i;
          2'd3:    n_q[idx*8 +: 8] <= data_i;
          default: ;
        endcase
      end
      if (rd_en) data_o <= rd_byte;
    end
  end

  // One modular-multiply step: P <- 2P mod N, then P <- P + A[j]*B mod N
  logic [WIDTH+1:0] n_ext, b_ext, p_dbl, p_s1, p_s2, p_nx;
  assign n_ext = {2'b00, n_w_q};
  assign b_ext = {2'b00, b_q};
  assign p_dbl = p_q << 1;
  assign p_s1  = (p_dbl >= n_ext) ? p_dbl - n_ext : p_dbl;
  assign p_s2  = a_q[WIDTH-1] ? p_s1 + b_ext : p_s1;
  assign p_nx  = (p_s2 >= n_ext) ? p_s2 - n_ext : p_s2;

  // The last multiply of a bit position is a MULT, or a SQUARE whose E bit is 0
  logic last_of_bit;
  assign last_of_bit = (op_q == OpMult) || (op_q == OpSquare && !e_w_q[bit_idx_q]);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_ok) state_d = StLoad;
      StLoad:    state_d = (n_q[WIDTH-1:1] == '0) ? StTriv : StMmSetup;
      StMmSetup: state_d = StMmIter;
      StMmIter: begin
        if (cnt_q == '0) begin
          state_d = (last_of_bit && bit_idx_q == '0) ? StDone : StMmSetup;
        end
      end
      StTriv:    state_d = StIdle;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= '0;
      m_w_q     <= '0;
      e_w_q     <= '0;
      n_w_q     <= '0;
      acc_q     <= '0;
      mr_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      op_q      <= OpReduce;
    end else begin
      unique case (state_q)
        StLoad: begin
          m_w_q     <= m_q;
          e_w_q     <= e_q;
          n_w_q     <= n_q;
          acc_q     <= WIDTH'(1);
          op_q      <= OpReduce;
          bit_idx_q <= CntW'(WIDTH - 1);
        end
        StMmSetup: begin
          p_q   <= '0;
          cnt_q <= CntW'(WIDTH - 1);
          unique case (op_q)
            OpReduce: begin a_q <= m_w_q; b_q <= WIDTH'(1); end
            OpSquare: begin a_q <= acc_q; b_q <= acc_q;     end
            default:  begin a_q <= acc_q; b_q <= mr_q;      end
          endcase
        end
        StMmIter: begin
          p_q   <= p_nx;
          a_q   <= a_q << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            unique case (op_q)
              OpReduce: begin
                mr_q <= p_nx[WIDTH-1:0];
                op_q <= OpSquare;
              end
              OpSquare: begin
                acc_q <= p_nx[WIDTH-1:0];
                if (e_w_q[bit_idx_q]) begin
                  op_q <= OpMult;
                end else begin
                  op_q      <= OpSquare;
                  bit_idx_q <= bit_idx_q - 1'b1;
                end
              end
              default: begin
                acc_q     <= p_nx[WIDTH-1:0];
                op_q      <= OpSquare;
                bit_idx_q <= bit_idx_q - 1'b1;
              end
            endcase
          end
        end
        StDone:  r_q <= acc_q;
        StTriv:  r_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
module tb_rsa_modexp;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              we, oe, start;
  logic [1:0]        reg_sel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_i;
  logic [7:0]        data_o;
  logic              ready;

  int tests_run    = 0;
  int tests_failed = 0;

  rsa_modexp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .oe      (oe),
    .start   (start),
    .reg_sel (reg_sel),
    .addr    (addr),
    .data_i  (data_i),
    .data_o  (data_o),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Bus helpers: all start and end on a falling edge.
  task automatic wr(input logic [1:0] sel, input logic [4:0] a, input logic [7:0] d);
    reg_sel = sel; addr = a; data_i = d; we = 1'b0;
    @(negedge clk);
    we = 1'b1;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [4:0] a, output logic [7:0] d);
    reg_sel = sel; addr = a; oe = 1'b0;
    @(negedge clk);
    oe = 1'b1;
    d = data_o;
  endtask

  task automatic wr16(input logic [1:0] sel, input logic [15:0] v);
    wr(sel, 5'd0, v[7:0]);
    wr(sel, 5'd1, v[15:8]);
  endtask

  task automatic rd16(input logic [1:0] sel, output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(sel, 5'd0, lo);
    rd(sel, 5'd1, hi);
    v = {hi, lo};
  endtask

  task automatic load(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n);
    wr16(2'd1, m);
    wr16(2'd2, e);
    wr16(2'd3, n);
  endtask

  // lat = number of rising edges after the accepting edge until ready is seen high
  task automatic run(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready got %b want 1", ready);
    end
    tests_run++;
    if (data_o !== 8'h00) begin
      tests_failed++; $display("FAIL reset_data_o got %h want 00", data_o);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 32; a++) begin
        rd(2'(s), 5'(a), d);
        tests_run++;
        if (d !== 8'h00) begin
          tests_failed++; $display("FAIL reset_read sel=%0d addr=%0d got %h want 00", s, a, d);
        end
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] d;
    wr(2'd1, 5'd1, 8'hA5);
    rd(2'd1, 5'd1, d);
    tests_run++;
    if (d !== 8'hA5) begin
      tests_failed++; $display("FAIL readback_m1 got %h want a5", d);
    end
    wr(2'd1, 5'd3, 8'h77);  // beyond WIDTH/8, ignored
    rd(2'd1, 5'd3, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL readback_oob got %h want 00", d);
    end
    wr(2'd0, 5'd0, 8'hFF);  // R is read-only
    rd(2'd0, 5'd0, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL readback_r_ro got %h want 00", d);
    end
    rd(2'd1, 5'd31, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL readback_addr31 got %h want 00", d);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] r;
    load(16'd4, 16'd13, 16'd497);
    run(lat);
    tests_run++;
    if (lat != 342) begin
      tests_failed++; $display("FAIL basic_latency got %0d want 342", lat);
    end
    rd16(2'd0, r);
    tests_run++;
    if (r !== 16'h01BD) begin
      tests_failed++; $display("FAIL basic_result got %0d want 445", r);
    end
  endtask

  task automatic test_trivial();
    int lat;
    logic [15:0] r;
    load(16'd5, 16'd3, 16'd0);
    run(lat);
    rd16(2'd0, r);
    tests_run++;
    if (lat != 2 || r !== 16'd0) begin
      tests_failed++; $display("FAIL trivial_n0 got lat=%0d r=%0d want lat=2 r=0", lat, r);
    end
    load(16'd3, 16'd0, 16'd7);
    run(lat);
    rd16(2'd0, r);
    tests_run++;
    if (r !== 16'd1) begin
      tests_failed++; $display("FAIL trivial_setup got %0d want 1", r);
    end
    load(16'd9, 16'd5, 16'd1);
    run(lat);
    rd16(2'd0, r);
    tests_run++;
    if (lat != 2 || r !== 16'd0) begin
      tests_failed++; $display("FAIL trivial_n1 got lat=%0d r=%0d want lat=2 r=0", lat, r);
    end
  endtask

  task automatic test_unreduced();
    int lat;
    logic [15:0] r;
    load(16'd1234, 16'd1, 16'd1000);
    run(lat);
    rd16(2'd0, r);
    tests_run++;
    if (lat != 308 || r !== 16'd234) begin
      tests_failed++; $display("FAIL unreduced_1234 got lat=%0d r=%0d want lat=308 r=234", lat, r);
    end
    load(16'd2, 16'd10, 16'd1000);
    run(lat);
    rd16(2'd0, r);
    tests_run++;
    if (lat != 325 || r !== 16'd24) begin
      tests_failed++; $display("FAIL unreduced_2p10 got lat=%0d r=%0d want lat=325 r=24", lat, r);
    end
    load(16'd3, 16'd0, 16'd7);
    run(lat);
    rd16(2'd0, r);
    tests_run++;
    if (lat != 291 || r !== 16'd1) begin
      tests_failed++; $display("FAIL unreduced_e0 got lat=%0d r=%0d want lat=291 r=1", lat, r);
    end
  endtask

  task automatic test_busy();
    int n;
    logic [15:0] v;
    logic [7:0]  d;
    load(16'd4, 16'd13, 16'd497);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    wr16(2'd3, 16'hFFFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd16(2'd0, v);
    tests_run++;
    if (v !== 16'd1) begin
      tests_failed++; $display("FAIL busy_r_prev got %0d want 1", v);
    end
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++; $display("FAIL busy_ready got %b want 0", ready);
    end
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rd16(2'd0, v);
    tests_run++;
    if (v !== 16'd445) begin
      tests_failed++; $display("FAIL busy_result got %0d want 445", v);
    end
    rd16(2'd3, v);
    tests_run++;
    if (v !== 16'd497) begin
      tests_failed++; $display("FAIL busy_n_locked got %0d want 497", v);
    end
    // Simultaneous strobes while idle: write commits, data_o holds
    rd(2'd1, 5'd0, d);
    reg_sel = 2'd1; addr = 5'd1; data_i = 8'h5A; we = 1'b0; oe = 1'b0;
    @(negedge clk);
    we = 1'b1; oe = 1'b1;
    tests_run++;
    if (data_o !== 8'h04) begin
      tests_failed++; $display("FAIL both_strobes_hold got %h want 04", data_o);
    end
    rd(2'd1, 5'd1, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++; $display("FAIL both_strobes_write got %h want 5a", d);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] v;
    logic [7:0]  d;
    load(16'd4, 16'd13, 16'd497);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (98) @(negedge clk);
    rd(2'd1, 5'd0, d);  // leaves data_o = 0x04
    reset = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b1 || data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_async got ready=%b data_o=%h want 1/00", ready, data_o);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd16(2'd0, v);
    tests_run++;
    if (v !== 16'd0) begin
      tests_failed++; $display("FAIL midreset_r got %0d want 0", v);
    end
    rd16(2'd3, v);
    tests_run++;
    if (v !== 16'd0) begin
      tests_failed++; $display("FAIL midreset_n got %0d want 0", v);
    end
    load(16'd4, 16'd13, 16'd497);
    run(lat);
    rd16(2'd0, v);
    tests_run++;
    if (lat != 342 || v !== 16'd445) begin
      tests_failed++; $display("FAIL midreset_rerun got lat=%0d r=%0d want lat=342 r=445", lat, v);
    end
  endtask

  initial begin
    we = 1'b1; oe = 1'b1; start = 1'b0;
    reg_sel = 2'd0; addr = '0; data_i = 8'h00;
    test_reset();
    test_readback();
    test_basic();
    test_trivial();
    test_unreduced();
    test_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
